branch_resolve: RTL
===================

Name: branch_resolve

Overview:
- ID-stage consumer of the branch comparator's Compare_result.
- Decides taken/not-taken for the branch instruction held in IF/ID and computes the branch target.
- Drives PC redirect and IF/ID flush; stalls IF and ID while branch operands are still in flight from EX/MEM.
- Keeps saturating-free performance counters for branches, taken branches and branch stall cycles.

Parameters:
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a valid instruction; 0 = bubble or externally flushed
id_branch  in  1  instruction in ID is a conditional branch (beq/bne/slt-type/blez/bltz/bgtz)
id_uses_rt  in  1  branch reads rt as the second comparator operand (beq/bne/slt-type)
id_rs  in  5  rs field of the branch
id_rt  in  5  rt field of the branch
id_pc_plus4  in  32  PC+4 of the branch
id_imm16  in  16  branch offset field
compare_result  in  32  comparator output; only bit 0 is used
ex_regwrite  in  1  instruction in EX writes a register
ex_memread  in  1  instruction in EX is a load
ex_rd  in  5  destination register of the EX instruction
mem_memread  in  1  instruction in MEM is a load
mem_rd  in  5  destination register of the MEM instruction
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
redirect  out  1  PC mux selects branch_target this cycle
branch_target  out  32  id_pc_plus4 + (sign_ext(id_imm16) << 2), mod 2^32
if_flush  out  1  squash the instruction currently in IF (the wrong-path fetch)
br_count  out  CNT_W  branches resolved since reset
taken_count  out  CNT_W  taken branches since reset
stall_count  out  CNT_W  cycles with stall=1 since reset

Behaviour:
- Operand match definition, for register r:
  - match(r) = (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt)).
- Hazard definition, hz:
  - hz = (ex_regwrite && match(ex_rd)) || (mem_memread && match(mem_rd)).
  - ex_memread implies ex_regwrite, so a load in EX is already covered.
  - A non-load ALU result in MEM is forwarded into ID by the existing forward path and is not a hazard.
- br = id_valid && id_branch.
- FSM states: IDLE, HOLD. Reset puts the FSM in IDLE.
- IDLE:
  - br && hz: stall=1; next state HOLD.
  - br && !hz: resolve (below); stay in IDLE.
  - Otherwise: all control outputs 0.
- HOLD:
  - !id_valid (external flush, e.g. exception): stall=0, no resolve, go to IDLE.
  - hz still true: stall=1, stay in HOLD.
  - hz false: resolve, go to IDLE.
  - The IF/ID contents are frozen by stall, so the branch fields are stable throughout HOLD.
- Resolve cycle (combinational on that cycle):
  - taken = compare_result[0].
  - redirect = taken; if_flush = taken; stall = 0.
  - br_count increments by 1; taken_count increments by 1 if taken.
  - Each branch is counted exactly once, however long it stalls.
- branch_target is combinational from the current ID fields and is always valid. Consumers qualify it with redirect.
- Delay slot: none. The predict-not-taken wrong-path fetch is removed by if_flush. Penalty is 1 cycle when taken, 0 when not taken.
- stall_count increments on every cycle with stall=1, including the entry cycle in IDLE.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset:
  - Takes effect at the clock edge, overriding everything else, including a resolve in the same cycle.
  - FSM goes to IDLE; all counters go to 0.
  - Combinational outputs (stall, redirect, if_flush) are 0 while reset=1.
- Back-to-back branches: a not-taken branch resolves in cycle N. A branch arriving in ID at N+1 is evaluated independently from IDLE.
- Outputs must never be X when id_valid=0, regardless of the other inputs.

Test Plan:
- Reset, then id_valid=1, id_branch=1, no hazard, compare_result=1, id_pc_plus4=0x0000_0104, id_imm16=0xFFFE -> same cycle: redirect=1, if_flush=1, stall=0, branch_target=0x0000_00FC. Next cycle: br_count=1, taken_count=1.
- Same branch with compare_result=0, id_imm16=0x0010 -> redirect=0, if_flush=0, branch_target=0x0000_0144, br_count increments, taken_count unchanged.
- Load-use: id_rs=5, ex_memread=1, ex_regwrite=1, ex_rd=5, then the load moves to MEM (mem_memread=1, mem_rd=5), then clears -> stall=1 for exactly 2 cycles, resolve on the 3rd cycle, stall_count=2, br_count=1.
- id_uses_rt=0, id_rt=7, ex_regwrite=1, ex_rd=7 -> no stall. Also ex_rd=0 with id_rs=0 -> no stall.
- Enter HOLD (id_rs=3, ex_regwrite=1, ex_rd=3), then drop id_valid -> FSM returns to IDLE, stall=0, br_count unchanged, no redirect.
- Assert reset during HOLD -> next cycle stall=0, all counters 0. Also preload counters to 2^CNT_W-1 (force or CNT_W=2 build) -> next resolve wraps the counter to 0.

Source files
------------

// File: rtl/branch_resolve_if.sv
// ID-stage branch resolution bundle: branch fields, hazard sources, control outputs
// and performance counters shared between the pipeline and branch_resolve.
interface branch_resolve_if #(
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic             id_branch;
    logic             id_uses_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [31:0]      id_pc_plus4;
    logic [15:0]      id_imm16;
    logic [31:0]      compare_result;
    logic             ex_regwrite;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             mem_memread;
    logic [4:0]       mem_rd;
    logic             stall;
    logic             redirect;
    logic [31:0]      branch_target;
    logic             if_flush;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_branch, id_uses_rt, id_rs, id_rt, id_pc_plus4, id_imm16,
               compare_result, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        input  stall, redirect, branch_target, if_flush, br_count, taken_count, stall_count
    );

    modport slave (
        input  id_valid, id_branch, id_uses_rt, id_rs, id_rt, id_pc_plus4, id_imm16,
               compare_result, ex_regwrite, ex_memread, ex_rd, mem_memread, mem_rd,
        output stall, redirect, branch_target, if_flush, br_count, taken_count, stall_count
    );
endinterface

// File: rtl/branch_resolve.sv
// Resolves the conditional branch held in IF/ID: hazard stall, taken decision,
// PC redirect / IF flush, target computation and wrapping performance counters.
module branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    branch_resolve_if.slave bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A nonzero destination that feeds either comparator operand of the branch.
    function automatic logic match_f(
        input logic [4:0] r,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       uses_rt
    );
        match_f = (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic             br_s;
    logic             hz_s;
    logic             taken_s;
    logic             stall_s;
    logic             resolve_s;
    logic [CNT_W-1:0] br_count_r;
    logic [CNT_W-1:0] taken_count_r;
    logic [CNT_W-1:0] stall_count_r;
    logic             unused_s;

    assign br_s     = bus.id_valid && bus.id_branch;
    // Only producers whose value cannot yet be forwarded into ID count as hazards.
    assign hz_s     = (bus.ex_regwrite && match_f(bus.ex_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt))
                   || (bus.mem_memread && match_f(bus.mem_rd, bus.id_rs, bus.id_rt, bus.id_uses_rt));
    assign taken_s  = bus.compare_result[0];
    assign unused_s = ^bus.compare_result[31:1];

    // State register; reset wins over any in-flight branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state, stall and resolve decode.
    always_comb begin
        state_nx_s = state_r;
        stall_s    = 1'b0;
        resolve_s  = 1'b0;
        if (reset) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (br_s && hz_s) begin
                        stall_s    = 1'b1;
                        state_nx_s = HOLD;
                    end else if (br_s) begin
                        resolve_s  = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                HOLD: begin
                    if (!bus.id_valid) begin
                        state_nx_s = IDLE;
                    end else if (hz_s) begin
                        stall_s    = 1'b1;
                    end else begin
                        resolve_s  = 1'b1;
                        state_nx_s = IDLE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // Performance counters, wrapping without saturation.
    always_ff @(posedge clk) begin
        if (reset) begin
            br_count_r    <= {CNT_W{1'b0}};
            taken_count_r <= {CNT_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            if (resolve_s) begin
                br_count_r <= br_count_r + CNT_ONE;
            end
            if (resolve_s && taken_s) begin
                taken_count_r <= taken_count_r + CNT_ONE;
            end
            if (stall_s) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end
        end
    end

    assign bus.stall         = stall_s;
    assign bus.redirect      = resolve_s ? taken_s : 1'b0;
    assign bus.if_flush      = resolve_s ? taken_s : 1'b0;
    assign bus.branch_target = bus.id_pc_plus4 + {{14{bus.id_imm16[15]}}, bus.id_imm16, 2'b00};
    assign bus.br_count      = br_count_r;
    assign bus.taken_count   = taken_count_r;
    assign bus.stall_count   = stall_count_r;
endmodule
